// File: rtl/in_port.sv
// Input port of the 16-bit SAP computer: buffers producer words in a small FIFO
// and drives the head word onto the OR-combined bus on in_read. Optional macro: IN_PORT_STATUS_EN.
module in_port #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   ext_data,
    input  logic          ext_valid,
    output logic          ext_ready,
    input  logic          in_read,
`ifdef IN_PORT_STATUS_EN
    input  logic          in_status,
`endif
    output logic [15:0]   bus_out,
    output logic          bus_drive,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          underflow
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("in_port: DEPTH must be a power of two in 2..16");
    end

    // Handshake: a word transfers at a rising edge when ext_valid && ext_ready.
    // ext_ready depends only on the registered count, so a stalled producer
    // must hold ext_data/ext_valid until the transfer happens.

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic push;
    logic pop;
    logic uf_event;
    logic status_rd;

    assign empty     = (count_q == CW'(0));
    assign full      = (count_q == CW'(DEPTH));
    assign ext_ready = !full;
    assign count     = count_q;

    assign push     = ext_valid && ext_ready;
    assign pop      = in_read && !empty;
    assign uf_event = in_read && empty;

`ifdef IN_PORT_STATUS_EN
    assign status_rd = in_status && !in_read;
`else
    assign status_rd = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ext_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (uf_event) begin
            underflow <= 1'b1;
        end else if (status_rd) begin
            underflow <= 1'b0;
        end
    end

`ifdef IN_PORT_STATUS_EN
    logic [15:0] status_word;

    always_comb begin
        status_word          = '0;
        status_word[15]      = underflow;
        status_word[14]      = full;
        status_word[13]      = empty;
        status_word[CW-1:0]  = count_q;
    end
`endif

    // Bus output must be all-zeros whenever this port is not driving real data.
    always_comb begin
        bus_out   = 16'h0000;
        bus_drive = in_read;
        if (pop) begin
            bus_out = mem[rd_ptr];
        end
`ifdef IN_PORT_STATUS_EN
        else if (status_rd) begin
            bus_drive = 1'b1;
            bus_out   = status_word;
        end
`endif
    end

endmodule
